// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
//   fetch_state_t : fetch FSM states (IDLE, FETCH, DROP)
//   INSTR_BYTES   : byte stride between sequential instructions
package instr_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a flush and a head output read from registers.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   push/push_data : write one entry (dropped if full and not popping)
//   pop            : remove head (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop
//   head           : current head entry (no combinational path from inputs)
//   count          : number of valid entries
//   full, empty    : status flags
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding request at a
// time to instruction memory and buffers {pc, instr} pairs for the datapath.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   imem_req/imem_addr             : memory request and its byte address
//   imem_ack/imem_rdata            : memory return strobe and instruction word
//   instr_valid/instr/instr_pc     : registered FIFO head towards the datapath
//   instr_ready                    : datapath consumes the head
//   redirect/redirect_pc           : taken branch/jump, flushes and retargets fetch
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned   N        = 16,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t   state_q, state_d;
  logic [N-1:0]   fetch_pc_q, fetch_pc_d;
  logic [N-1:0]   req_addr_q, req_addr_d;
  logic [N-1:0]   next_seq_pc;

  logic           fifo_push, fifo_pop, fifo_flush;
  logic [2*N-1:0] fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full, fifo_empty;
  logic [CW:0]    post_push_count;
  logic           space_after_push;

  assign next_seq_pc = fetch_pc_q + N'(INSTR_BYTES);

  // Occupancy after this cycle's push, accounting for a simultaneous pop.
  assign post_push_count  = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);
  assign space_after_push = (post_push_count < (CW+1)'(DEPTH));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!fifo_full) begin
          state_d    = FETCH;
          req_addr_d = fetch_pc_q;
        end
      end
      FETCH: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          // A request cannot be withdrawn; without the ack it must drain in DROP.
          state_d    = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          fetch_pc_d = next_seq_pc;
          if (space_after_push) begin
            req_addr_d = next_seq_pc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and FIFO control
  always_comb begin
    imem_req   = (state_q != IDLE);
    imem_addr  = req_addr_q;
    fifo_push  = (state_q == FETCH) && imem_ack && !redirect;
    fifo_pop   = !fifo_empty && instr_ready && !redirect;
    fifo_flush = redirect;
  end

  sync_fifo #(
    .WIDTH (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({req_addr_q, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid       = !fifo_empty;
  assign {instr_pc, instr} = fifo_head;

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        rdata_ovr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {pc, instr} expected at the FIFO head, in order.
  logic [31:0] sb_q[$];
  logic [15:0] exp_fetch;
  bit          drop_pending;

  always #5 clk = ~clk;

  // Memory model: word is a simple function of the address unless overridden.
  assign imem_rdata = rdata_ovr ? 16'hDEAD : (imem_addr ^ 16'h5A5A);

  instr_prefetch #(
    .N        (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_fetch    = 16'h0000;
    drop_pending = 1'b0;
  endtask

  // Called at posedge+1 with inputs set: predict the coming edge, step, then check.
  task automatic cycle();
    logic [31:0] h;
    if (instr_valid && instr_ready && !redirect && sb_q.size() != 0) begin
      void'(sb_q.pop_front());
    end
    if (imem_req && imem_ack) begin
      if (redirect || drop_pending) begin
        drop_pending = 1'b0;
      end else begin
        check_eq("fetch_addr", imem_addr, exp_fetch);
        sb_q.push_back({imem_addr, imem_rdata});
        exp_fetch = exp_fetch + 16'd2;
      end
    end else if (imem_req && redirect) begin
      drop_pending = 1'b1;
    end
    if (redirect) begin
      sb_q.delete();
      exp_fetch = redirect_pc;
    end
    @(posedge clk);
    #1;
    check_eq("valid", instr_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      h = sb_q[0];
      check_eq("head_pc", instr_pc, h[31:16]);
      check_eq("head_instr", instr, h[15:0]);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must go to reset values with no edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 16'h0000);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, 16'h0000);
    check_eq("rst_pc", instr_pc, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Reset/start: zero-wait memory, always ready.
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    do_reset();
    check_eq("start_idle", imem_req, 1'b0);
    cycle();
    check_eq("start_req", imem_req, 1'b1);
    check_eq("start_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      check_eq("seq_addr", imem_addr, 16'(2 * i));
      cycle();
      check_eq("seq_pc", instr_pc, 16'(2 * i));
    end

    // Backpressure: fill to four entries, then one pop lets one more fetch in.
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    do_reset();
    cycle();
    repeat (4) cycle();
    check_eq("bp_req_off", imem_req, 1'b0);
    check_eq("bp_head", instr_pc, 16'h0000);
    repeat (2) begin
      cycle();
      check_eq("bp_req_hold", imem_req, 1'b0);
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    check_eq("bp_pop_head", instr_pc, 16'h0002);
    cycle();
    check_eq("bp_refetch_req", imem_req, 1'b1);
    check_eq("bp_refetch_addr", imem_addr, 16'h0008);
    cycle();
    check_eq("bp_full_again", imem_req, 1'b0);

    // Wait states: ack on the third cycle of each request.
    instr_ready = 1'b1;
    imem_ack    = 1'b0;
    do_reset();
    cycle();
    for (int k = 0; k < 4; k++) begin
      check_eq("ws_addr", imem_addr, 16'(2 * k));
      repeat (2) begin
        cycle();
        check_eq("ws_hold_addr", imem_addr, 16'(2 * k));
        check_eq("ws_hold_req", imem_req, 1'b1);
      end
      imem_ack = 1'b1;
      cycle();
      imem_ack = 1'b0;
      check_eq("ws_pc", instr_pc, 16'(2 * k));
    end

    // Redirect while the request to 0004 is outstanding; its data must be dropped.
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    do_reset();
    repeat (3) cycle();
    imem_ack = 1'b0;
    check_eq("rd_outstanding", imem_addr, 16'h0004);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    cycle();
    redirect = 1'b0;
    check_eq("rd_drop_req", imem_req, 1'b1);
    check_eq("rd_drop_addr", imem_addr, 16'h0004);
    cycle();
    rdata_ovr = 1'b1;
    imem_ack  = 1'b1;
    cycle();
    rdata_ovr = 1'b0;
    check_eq("rd_idle_req", imem_req, 1'b0);
    check_eq("rd_no_dead", instr_valid, 1'b0);
    cycle();
    check_eq("rd_new_req", imem_req, 1'b1);
    check_eq("rd_new_addr", imem_addr, 16'h0100);
    cycle();
    check_eq("rd_next_addr", imem_addr, 16'h0102);
    check_eq("rd_new_pc", instr_pc, 16'h0100);

    // Redirect + ack + pop together with three entries buffered.
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    do_reset();
    repeat (4) cycle();
    check_eq("sim_addr", imem_addr, 16'h0006);
    check_eq("sim_head", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    cycle();
    redirect = 1'b0;
    check_eq("sim_flushed", instr_valid, 1'b0);
    check_eq("sim_idle", imem_req, 1'b0);
    cycle();
    check_eq("sim_new_addr", imem_addr, 16'h0200);
    // Sequential wrap from FFFE.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    cycle();
    redirect = 1'b0;
    check_eq("wrap_idle", imem_req, 1'b0);
    cycle();
    check_eq("wrap_addr0", imem_addr, 16'hFFFE);
    cycle();
    check_eq("wrap_addr1", imem_addr, 16'h0000);
    check_eq("wrap_pc", instr_pc, 16'hFFFE);
    cycle();
    check_eq("wrap_addr2", imem_addr, 16'h0002);

    // Async reset with a full FIFO, then again while draining in DROP.
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    do_reset();
    repeat (5) cycle();
    check_eq("full_valid", instr_valid, 1'b1);
    check_eq("full_req", imem_req, 1'b0);
    do_reset();
    cycle();
    check_eq("restart_addr", imem_addr, 16'h0000);
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    cycle();
    redirect_pc = 16'h0400;
    cycle();
    redirect = 1'b0;
    check_eq("drop_req", imem_req, 1'b1);
    check_eq("drop_addr", imem_addr, 16'h0000);
    do_reset();
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    cycle();
    check_eq("restart2_addr", imem_addr, 16'h0000);
    repeat (3) cycle();
    check_eq("restart2_pc", instr_pc, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
